// File: rtl/spi_master_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : spi_master_if
// Brief  : Command handshake plus 4-wire SPI pins for the spi_master block.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
interface spi_master_if;
    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs_n;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, sclk, mosi, cs_n
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, sclk, mosi, cs_n
    );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : spi_master
// Brief  : SPI mode-0 initiator, one byte per transfer, MSB first.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module spi_master #(
    parameter int CLK_DIV = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    spi_master_if.master  bus
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_shift = 2'd1;
    localparam logic [1:0]  c_st_hold  = 2'd2;
    localparam logic [15:0] c_div_last = 16'(CLK_DIV - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx;
    logic [7:0]  r_rx_data;
    logic        r_sclk;
    logic        r_cs_n;
    logic        r_busy;
    logic        r_done;
    logic        w_term;

    assign w_term = (r_cnt == c_div_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (bus.start) begin
                    w_state_nxt = c_st_shift;
                end
            end
            c_st_shift: begin
                // The 8th falling sclk edge ends the shift phase.
                if (w_term && r_sclk && (r_bit_cnt == 3'd7)) begin
                    w_state_nxt = c_st_hold;
                end
            end
            c_st_hold: begin
                if (w_term) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_cs_n <= (w_state_nxt == c_st_idle);
            r_busy <= (w_state_nxt != c_st_idle);
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_sclk <= 1'b0;
                    if (bus.start) begin
                        r_tx      <= bus.tx_data;
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                c_st_shift: begin
                    if (w_term) begin
                        r_cnt  <= '0;
                        r_sclk <= ~r_sclk;
                        if (!r_sclk) begin
                            r_rx <= {r_rx[6:0], bus.miso};
                        end else begin
                            r_tx      <= {r_tx[6:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                c_st_hold: begin
                    if (w_term) begin
                        r_cnt     <= '0;
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // mosi follows the shift register MSB, so the first bit is set up in the first SHIFT cycle.
    assign bus.mosi    = r_tx[7];
    assign bus.sclk    = r_sclk;
    assign bus.cs_n    = r_cs_n;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_spi_master
// Brief  : Directed and randomized transfers against a byte-level SPI model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_spi_master;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_master_if bus0 ();
    spi_master_if bus1 ();

    spi_master #(.CLK_DIV(2)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    spi_master #(.CLK_DIV(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    assign bus1.miso = bus1.mosi;

    int n_assert = 0;
    int n_fail   = 0;

    // Responder and bus monitor for the CLK_DIV=2 instance, evaluated mid-cycle.
    logic [7:0] resp_byte;
    logic [7:0] resp_sh   = 8'h00;
    logic [7:0] mosi_cap  = 8'h00;
    int         rise_cnt  = 0;
    logic       prev_sclk = 1'b0;
    logic       prev_cs_n = 1'b1;

    always @(negedge clk) begin
        if (bus0.sclk && !prev_sclk) begin
            rise_cnt = rise_cnt + 1;
            mosi_cap = {mosi_cap[6:0], bus0.mosi};
        end
        if (prev_cs_n && !bus0.cs_n) begin
            resp_sh = resp_byte;
        end else if (!bus0.sclk && prev_sclk && !bus0.cs_n) begin
            resp_sh = {resp_sh[6:0], 1'b0};
        end
        bus0.miso = resp_sh[7];
        prev_sclk = bus0.sclk;
        prev_cs_n = bus0.cs_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One byte on the CLK_DIV=2 instance; expected values come from the byte-level model.
    task automatic xfer0(input logic [7:0] tx, input logic [7:0] resp, input bit keep,
                         input int poke, input string tag);
        int base;
        int dc;
        base = rise_cnt;
        resp_byte = resp;
        bus0.tx_data = tx;
        bus0.start = 1'b1;
        @(negedge clk);
        if (!keep) bus0.start = 1'b0;
        check({tag, "_cycle1"}, {bus0.busy, bus0.cs_n, bus0.sclk, bus0.mosi},
              {1'b1, 1'b0, 1'b0, tx[7]});
        dc = -1;
        for (int n = 1; n <= 200; n++) begin
            if (bus0.done) begin
                dc = n;
                break;
            end
            if (n == poke) begin
                bus0.tx_data = 8'hFF;
                bus0.start = 1'b1;
            end else if (n == poke + 1) begin
                bus0.start = 1'b0;
                bus0.tx_data = tx;
            end
            @(negedge clk);
        end
        check({tag, "_done_cycle"}, dc, 1 + 17 * 2);
        check({tag, "_rx_data"}, bus0.rx_data, resp);
        check({tag, "_mosi_bits"}, mosi_cap, tx);
        check({tag, "_rise_edges"}, rise_cnt - base, 8);
        check({tag, "_done_state"}, {bus0.cs_n, bus0.busy, bus0.sclk}, 3'b100);
    endtask

    // Loopback byte on the CLK_DIV=1 instance.
    task automatic xfer1(input logic [7:0] tx, input string tag);
        int dc;
        bus1.tx_data = tx;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        dc = -1;
        for (int n = 1; n <= 100; n++) begin
            if (bus1.done) begin
                dc = n;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done_cycle"}, dc, 1 + 17 * 1);
        check({tag, "_rx_data"}, bus1.rx_data, tx);
    endtask

    initial begin
        logic bad;
        rst = 1'b1;
        resp_byte = 8'h00;
        bus0.start = 1'b0;
        bus0.tx_data = 8'h00;
        bus1.start = 1'b0;
        bus1.tx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values hold while idle.
        for (int i = 0; i < 100; i++) begin
            check("reset_idle",
                  {bus0.cs_n, bus0.sclk, bus0.mosi, bus0.busy, bus0.done, bus0.rx_data},
                  {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
            @(negedge clk);
        end

        xfer0(8'hA5, 8'h3C, 1'b0, -1, "basic");
        @(negedge clk);
        check("basic_done_pulse", bus0.done, 1'b0);

        // start during busy is dropped.
        repeat (3) @(negedge clk);
        xfer0(8'h00, 8'hC3, 1'b0, 10, "busy_reject");
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus0.done || !bus0.cs_n || bus0.busy) bad = 1'b1;
        end
        check("busy_reject_no_second", bad, 1'b0);

        // Back-to-back with start held high.
        xfer0(8'h81, 8'h18, 1'b1, -1, "b2b_first");
        xfer0(8'h7E, 8'hE7, 1'b0, -1, "b2b_second");

        for (int i = 0; i < 6; i++) begin
            logic [7:0] t;
            logic [7:0] r;
            t = 8'($urandom);
            r = 8'($urandom_range(1, 255));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xfer0(t, r, 1'b0, -1, "random");
        end

        // Reset in cycle 12 of a transfer.
        bus0.tx_data = 8'h96;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_outputs",
              {bus0.cs_n, bus0.sclk, bus0.mosi, bus0.busy, bus0.done, bus0.rx_data},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus0.done || !bus0.cs_n) bad = 1'b1;
        end
        check("midreset_no_done", bad, 1'b0);
        xfer0(8'hC5, 8'h5C, 1'b0, -1, "after_reset");

        xfer1(8'h5A, "loopback");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            xfer1(8'($urandom), "loopback_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
